// File: rtl/ghost_mode_scheduler.sv
// Global ghost mode sequencer: scatter/chase schedule, frightened
// window with end-of-fright flash, and ghost reversal pulses.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   tick             one-cycle game-time pulse
//   enable           game running; low freezes timers, ignores pellets
//   levelStart       synchronous schedule restart (highest priority)
//   powerPellet      one-cycle pellet-eaten pulse
//   isChase          chase mode to ghosts
//   isScatter        scatter mode to ghosts
//   isFrightened     frightened mode
//   frightFlash      frightened-ending warning
//   reverseDir       one-cycle ghost reversal pulse
//   phaseIdx         current schedule phase 0..7
//   frightRemain     remaining frightened ticks
module ghost_mode_scheduler #(
    parameter int TIMER_W      = 8,
    parameter int SC1_TICKS    = 7,
    parameter int CH1_TICKS    = 20,
    parameter int SC2_TICKS    = 7,
    parameter int CH2_TICKS    = 20,
    parameter int SC3_TICKS    = 5,
    parameter int CH3_TICKS    = 20,
    parameter int SC4_TICKS    = 5,
    parameter int FRIGHT_TICKS = 6,
    parameter int FLASH_TICKS  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               enable,
    input  logic               levelStart,
    input  logic               powerPellet,
    output logic               isChase,
    output logic               isScatter,
    output logic               isFrightened,
    output logic               frightFlash,
    output logic               reverseDir,
    output logic [2:0]         phaseIdx,
    output logic [TIMER_W-1:0] frightRemain
);

    localparam logic [2:0] LAST_PHASE = 3'd7;
    localparam logic [TIMER_W-1:0] FRIGHT_LEN = TIMER_W'(FRIGHT_TICKS);
    localparam logic [TIMER_W-1:0] FLASH_LEN  = TIMER_W'(FLASH_TICKS);
    localparam logic [TIMER_W-1:0] ONE        = TIMER_W'(1);

    // Length of each scheduled phase; phase 7 never counts.
    function automatic logic [TIMER_W-1:0] phase_len(input logic [2:0] p);
        logic [TIMER_W-1:0] len;
        len = '0;
        case (p)
            3'd0: len = TIMER_W'(SC1_TICKS);
            3'd1: len = TIMER_W'(CH1_TICKS);
            3'd2: len = TIMER_W'(SC2_TICKS);
            3'd3: len = TIMER_W'(CH2_TICKS);
            3'd4: len = TIMER_W'(SC3_TICKS);
            3'd5: len = TIMER_W'(CH3_TICKS);
            3'd6: len = TIMER_W'(SC4_TICKS);
            default: len = '0;
        endcase
        return len;
    endfunction

    logic [TIMER_W-1:0] phase_timer;
    logic [TIMER_W-1:0] timer_n;
    logic [TIMER_W-1:0] remain_n;
    logic [2:0]         phase_n;
    logic               fright_n;
    logic               rev_n;

    // A pellet outranks both fright countdown and phase expiry, so a
    // coincident expiry tick leaves the phase timer untouched and only
    // the pellet's reversal is issued.
    always_comb begin
        phase_n  = phaseIdx;
        timer_n  = phase_timer;
        remain_n = frightRemain;
        fright_n = isFrightened;
        rev_n    = 1'b0;
        if (enable) begin
            if (powerPellet) begin
                remain_n = FRIGHT_LEN;
                fright_n = (FRIGHT_TICKS != 0);
                rev_n    = 1'b1;
            end else if (isFrightened) begin
                if (tick) begin
                    if (frightRemain != '0)
                        remain_n = frightRemain - ONE;
                    if (frightRemain <= ONE)
                        fright_n = 1'b0;
                end
            end else if (tick && phaseIdx != LAST_PHASE) begin
                if (phase_timer <= ONE) begin
                    phase_n = phaseIdx + 3'd1;
                    timer_n = phase_len(phaseIdx + 3'd1);
                    rev_n   = 1'b1;
                end else begin
                    timer_n = phase_timer - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phaseIdx     <= '0;
            phase_timer  <= TIMER_W'(SC1_TICKS);
            isScatter    <= 1'b1;
            isChase      <= 1'b0;
            isFrightened <= 1'b0;
            frightRemain <= '0;
            frightFlash  <= 1'b0;
            reverseDir   <= 1'b0;
        end else if (levelStart) begin
            phaseIdx     <= '0;
            phase_timer  <= TIMER_W'(SC1_TICKS);
            isScatter    <= 1'b1;
            isChase      <= 1'b0;
            isFrightened <= 1'b0;
            frightRemain <= '0;
            frightFlash  <= 1'b0;
            reverseDir   <= 1'b0;
        end else begin
            phaseIdx     <= phase_n;
            phase_timer  <= timer_n;
            frightRemain <= remain_n;
            isFrightened <= fright_n;
            reverseDir   <= rev_n;
            isChase      <= !fright_n && phase_n[0];
            isScatter    <= !fright_n && !phase_n[0];
            frightFlash  <= fright_n && (remain_n <= FLASH_LEN)
                            && (remain_n != '0);
        end
    end

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Directed testbench for ghost_mode_scheduler.
// Scenario tasks each drive stimulus and check outputs inline.
module tb_ghost_mode_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       enable;
    logic       levelStart;
    logic       powerPellet;
    logic       isChase;
    logic       isScatter;
    logic       isFrightened;
    logic       frightFlash;
    logic       reverseDir;
    logic [2:0] phaseIdx;
    logic [7:0] frightRemain;

    int total = 0;
    int bad   = 0;

    ghost_mode_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .enable       (enable),
        .levelStart   (levelStart),
        .powerPellet  (powerPellet),
        .isChase      (isChase),
        .isScatter    (isScatter),
        .isFrightened (isFrightened),
        .frightFlash  (frightFlash),
        .reverseDir   (reverseDir),
        .phaseIdx     (phaseIdx),
        .frightRemain (frightRemain)
    );

    always #5 clk = ~clk;

    // flags = {isChase, isScatter, isFrightened, frightFlash, reverseDir}
    function automatic logic [4:0] flags();
        return {isChase, isScatter, isFrightened, frightFlash, reverseDir};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        tick = 1'b0;
        powerPellet = 1'b0;
        enable = 1'b1;
        levelStart = 1'b1;
        step();
        levelStart = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick = 1'b0;
        enable = 1'b0;
        levelStart = 1'b0;
        powerPellet = 1'b0;
        #23;
        reset = 1'b0;
        #1;
        total++;
        if (flags() !== 5'b01000 || phaseIdx !== 3'd0
            || frightRemain !== 8'd0) begin
            bad++;
            $display("FAIL reset: flags=%b phase=%0d rem=%0d want 01000/0/0",
                     flags(), phaseIdx, frightRemain);
        end
    endtask

    task automatic test_schedule();
        int n;
        int pulses;
        logic prev;
        enable = 1'b1;
        tick = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            total++;
            if (flags() !== 5'b01000 || phaseIdx !== 3'd0) begin
                bad++;
                $display("FAIL sched_scatter t%0d: flags=%b phase=%0d want 01000/0",
                         i, flags(), phaseIdx);
            end
        end
        step();
        total++;
        if (flags() !== 5'b10001 || phaseIdx !== 3'd1) begin
            bad++;
            $display("FAIL sched_first_chase: flags=%b phase=%0d want 10001/1",
                     flags(), phaseIdx);
        end
        n = 7;
        pulses = 1;
        prev = 1'b1;
        step();
        n++;
        total++;
        if (reverseDir !== 1'b0) begin
            bad++;
            $display("FAIL sched_rev_width: rev=%b want 0", reverseDir);
        end
        prev = 1'b0;
        while (phaseIdx !== 3'd7 && n < 200) begin
            step();
            n++;
            if (reverseDir === 1'b1) begin
                pulses++;
                if (prev) begin
                    total++;
                    bad++;
                    $display("FAIL sched_rev_double: at tick %0d", n);
                end
            end
            prev = reverseDir;
        end
        total++;
        if (n !== 84 || pulses !== 7) begin
            bad++;
            $display("FAIL sched_to_7: ticks=%0d pulses=%0d want 84/7",
                     n, pulses);
        end
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (reverseDir === 1'b1 || phaseIdx !== 3'd7 || isChase !== 1'b1)
                pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL sched_phase7_hold: bad_cycles=%0d want 0", pulses);
        end
        tick = 1'b0;
    endtask

    task automatic test_fright();
        restart();
        tick = 1'b1;
        for (int i = 0; i < 17; i++) step();
        tick = 1'b0;
        powerPellet = 1'b1;
        step();
        powerPellet = 1'b0;
        total++;
        if (flags() !== 5'b00101 || frightRemain !== 8'd6
            || phaseIdx !== 3'd1) begin
            bad++;
            $display("FAIL fright_enter: flags=%b rem=%0d ph=%0d want 00101/6/1",
                     flags(), frightRemain, phaseIdx);
        end
        tick = 1'b1;
        for (int r = 5; r >= 1; r--) begin
            step();
            total++;
            if (frightRemain !== 8'(r) || isFrightened !== 1'b1
                || frightFlash !== (r <= 2) || reverseDir !== 1'b0) begin
                bad++;
                $display("FAIL fright_count r%0d: rem=%0d fl=%b fr=%b rev=%b",
                         r, frightRemain, frightFlash, isFrightened, reverseDir);
            end
        end
        step();
        total++;
        if (flags() !== 5'b10000 || frightRemain !== 8'd0) begin
            bad++;
            $display("FAIL fright_exit: flags=%b rem=%0d want 10000/0",
                     flags(), frightRemain);
        end
        for (int i = 0; i < 9; i++) step();
        total++;
        if (phaseIdx !== 3'd1) begin
            bad++;
            $display("FAIL fright_timer_kept9: phase=%0d want 1", phaseIdx);
        end
        step();
        total++;
        if (phaseIdx !== 3'd2 || flags() !== 5'b01001) begin
            bad++;
            $display("FAIL fright_timer_kept10: ph=%0d flags=%b want 2/01001",
                     phaseIdx, flags());
        end
        tick = 1'b0;
    endtask

    task automatic test_reload();
        restart();
        powerPellet = 1'b1;
        step();
        powerPellet = 1'b0;
        tick = 1'b1;
        for (int i = 0; i < 3; i++) step();
        powerPellet = 1'b1;
        step();
        powerPellet = 1'b0;
        total++;
        if (flags() !== 5'b00101 || frightRemain !== 8'd6) begin
            bad++;
            $display("FAIL reload_at3: flags=%b rem=%0d want 00101/6",
                     flags(), frightRemain);
        end
        for (int i = 0; i < 5; i++) step();
        total++;
        if (flags() !== 5'b00110 || frightRemain !== 8'd1) begin
            bad++;
            $display("FAIL reload_pre1: flags=%b rem=%0d want 00110/1",
                     flags(), frightRemain);
        end
        powerPellet = 1'b1;
        step();
        powerPellet = 1'b0;
        total++;
        if (flags() !== 5'b00101 || frightRemain !== 8'd6) begin
            bad++;
            $display("FAIL reload_at1: flags=%b rem=%0d want 00101/6",
                     flags(), frightRemain);
        end
        step();
        total++;
        if (flags() !== 5'b00100 || frightRemain !== 8'd5) begin
            bad++;
            $display("FAIL reload_after: flags=%b rem=%0d want 00100/5",
                     flags(), frightRemain);
        end
        tick = 1'b0;
    endtask

    task automatic test_collision();
        restart();
        tick = 1'b1;
        for (int i = 0; i < 6; i++) step();
        powerPellet = 1'b1;
        step();
        powerPellet = 1'b0;
        tick = 1'b0;
        total++;
        if (phaseIdx !== 3'd0 || flags() !== 5'b00101) begin
            bad++;
            $display("FAIL collide_pellet: ph=%0d flags=%b want 0/00101",
                     phaseIdx, flags());
        end
        step();
        total++;
        if (reverseDir !== 1'b0) begin
            bad++;
            $display("FAIL collide_single_rev: rev=%b want 0", reverseDir);
        end
        tick = 1'b1;
        for (int i = 0; i < 6; i++) step();
        total++;
        if (flags() !== 5'b01000 || phaseIdx !== 3'd0) begin
            bad++;
            $display("FAIL collide_resume: flags=%b ph=%0d want 01000/0",
                     flags(), phaseIdx);
        end
        step();
        total++;
        if (flags() !== 5'b10001 || phaseIdx !== 3'd1) begin
            bad++;
            $display("FAIL collide_advance: flags=%b ph=%0d want 10001/1",
                     flags(), phaseIdx);
        end
        tick = 1'b0;
    endtask

    task automatic test_level_start();
        restart();
        tick = 1'b1;
        for (int i = 0; i < 34; i++) step();
        tick = 1'b0;
        powerPellet = 1'b1;
        step();
        powerPellet = 1'b0;
        total++;
        if (phaseIdx !== 3'd3 || isFrightened !== 1'b1) begin
            bad++;
            $display("FAIL ls_setup: ph=%0d fr=%b want 3/1",
                     phaseIdx, isFrightened);
        end
        tick = 1'b1;
        levelStart = 1'b1;
        step();
        levelStart = 1'b0;
        tick = 1'b0;
        total++;
        if (flags() !== 5'b01000 || phaseIdx !== 3'd0
            || frightRemain !== 8'd0) begin
            bad++;
            $display("FAIL ls_restart: flags=%b ph=%0d rem=%0d want 01000/0/0",
                     flags(), phaseIdx, frightRemain);
        end
    endtask

    task automatic test_enable();
        restart();
        powerPellet = 1'b1;
        step();
        powerPellet = 1'b0;
        enable = 1'b0;
        tick = 1'b1;
        step();
        total++;
        if (flags() !== 5'b00100 || frightRemain !== 8'd6) begin
            bad++;
            $display("FAIL en_rev_drop: flags=%b rem=%0d want 00100/6",
                     flags(), frightRemain);
        end
        for (int i = 0; i < 5; i++) begin
            powerPellet = (i == 2);
            step();
        end
        powerPellet = 1'b0;
        total++;
        if (flags() !== 5'b00100 || frightRemain !== 8'd6
            || phaseIdx !== 3'd0) begin
            bad++;
            $display("FAIL en_fright_hold: flags=%b rem=%0d ph=%0d",
                     flags(), frightRemain, phaseIdx);
        end
        restart();
        enable = 1'b0;
        tick = 1'b1;
        for (int i = 0; i < 10; i++) begin
            powerPellet = (i == 4);
            step();
        end
        powerPellet = 1'b0;
        total++;
        if (flags() !== 5'b01000 || phaseIdx !== 3'd0) begin
            bad++;
            $display("FAIL en_sched_hold: flags=%b ph=%0d want 01000/0",
                     flags(), phaseIdx);
        end
        enable = 1'b1;
        for (int i = 0; i < 6; i++) step();
        total++;
        if (phaseIdx !== 3'd0) begin
            bad++;
            $display("FAIL en_timer_frozen: ph=%0d want 0", phaseIdx);
        end
        step();
        total++;
        if (phaseIdx !== 3'd1) begin
            bad++;
            $display("FAIL en_timer_resume: ph=%0d want 1", phaseIdx);
        end
        tick = 1'b0;
    endtask

    task automatic test_async_reset();
        restart();
        powerPellet = 1'b1;
        step();
        powerPellet = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (flags() !== 5'b01000 || frightRemain !== 8'd0) begin
            bad++;
            $display("FAIL async_reset: flags=%b rem=%0d want 01000/0",
                     flags(), frightRemain);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_schedule();
        test_fright();
        test_reload();
        test_collision();
        test_level_start();
        test_enable();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
